// File: rtl/cpu_pkg.sv
// Shared encodings for the 8-bit CPU: opcodes, sequencer state codes,
// instruction field positions and the instruction-class one-hot layout.
package cpu_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_LW  = 2'b01;
    localparam logic [1:0] OP_SW  = 2'b10;
    localparam logic [1:0] OP_J   = 2'b11;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_DECODE = 3'd2;
    localparam logic [2:0] ST_EXEC   = 3'd3;
    localparam logic [2:0] ST_MEM    = 3'd4;
    localparam logic [2:0] ST_WB     = 3'd5;
    localparam logic [2:0] ST_HALT   = 3'd6;

    localparam int OP_HI   = 7;
    localparam int OP_LO   = 6;
    localparam int RS_HI   = 5;
    localparam int RS_LO   = 4;
    localparam int RT_HI   = 3;
    localparam int RT_LO   = 2;
    localparam int RD_HI   = 1;
    localparam int RD_LO   = 0;
    localparam int JOFF_HI = 5;

    // Class one-hot bit index equals the opcode value.
    localparam int CLS_ADD = 0;
    localparam int CLS_LW  = 1;
    localparam int CLS_SW  = 2;
    localparam int CLS_J   = 3;

endpackage

// File: rtl/instr_decoder.sv
// Combinational instruction decoder: splits IR into register fields,
// builds the sign-extended immediate and a one-hot instruction class.
module instr_decoder
    import cpu_pkg::*;
(
    input  logic [7:0] ir,
    output logic [1:0] opcode,
    output logic [1:0] rs_sel,
    output logic [1:0] rt_sel,
    output logic [1:0] rd_sel,
    output logic [7:0] imm,
    output logic [3:0] cls
);

    always_comb begin
        opcode      = ir[OP_HI:OP_LO];
        rs_sel      = ir[RS_HI:RS_LO];
        rt_sel      = ir[RT_HI:RT_LO];
        rd_sel      = ir[RD_HI:RD_LO];
        cls         = '0;
        cls[opcode] = 1'b1;
        case (opcode)
            OP_LW, OP_SW: imm = {{6{ir[RD_HI]}}, ir[RD_HI:RD_LO]};
            OP_J:         imm = {{2{ir[JOFF_HI]}}, ir[JOFF_HI:0]};
            default:      imm = 8'h00;
        endcase
    end

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/decode/execute controller: owns the PC, IR and retired counter and
// emits per-state datapath strobes. Define STEP_EN to add the single-step port.
module instr_sequencer
    import cpu_pkg::*;
#(
    parameter int PROG_LEN = 8,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
`ifdef STEP_EN
    input  logic             step,
`endif
    output logic [7:0]       imem_addr,
    input  logic [7:0]       imem_data,
    output logic [7:0]       pc,
    output logic [1:0]       opcode,
    output logic [1:0]       rs_sel,
    output logic [1:0]       rt_sel,
    output logic [1:0]       rd_sel,
    output logic [7:0]       imm,
    output logic             alu_src,
    output logic             reg_we,
    output logic             mem_re,
    output logic             mem_we,
    output logic             mem_to_reg,
    output logic             busy,
    output logic             halted,
    output logic [CNT_W-1:0] instr_count
);

    localparam logic [8:0] PROG_LIM = 9'(PROG_LEN);

    logic [2:0]       state_q, state_d;
    logic [7:0]       pc_q, pc_d;
    logic [7:0]       ir_q, ir_d;
    logic [1:0]       opcode_q, opcode_d, rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
    logic [7:0]       imm_q, imm_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [1:0] dec_opcode, dec_rs, dec_rt, dec_rd;
    logic [7:0] dec_imm;
    logic [3:0] cls;
    logic       start, retire, mem_op;

`ifdef STEP_EN
    assign start = run | step;
`else
    assign start = run;
`endif

    // IR is held from FETCH to the next FETCH, so the class stays valid all instruction.
    instr_decoder u_dec (
        .ir     (ir_q),
        .opcode (dec_opcode),
        .rs_sel (dec_rs),
        .rt_sel (dec_rt),
        .rd_sel (dec_rd),
        .imm    (dec_imm),
        .cls    (cls)
    );

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        opcode_d = opcode_q;
        rs_d     = rs_q;
        rt_d     = rt_q;
        rd_d     = rd_q;
        imm_d    = imm_q;
        cnt_d    = cnt_q;
        retire   = 1'b0;
        case (state_q)
            ST_IDLE:   if (start) state_d = ST_FETCH;
            ST_FETCH: begin
                ir_d    = imem_data;
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                opcode_d = dec_opcode;
                rs_d     = dec_rs;
                rt_d     = dec_rt;
                rd_d     = dec_rd;
                imm_d    = dec_imm;
                state_d  = ST_EXEC;
            end
            ST_EXEC: begin
                if (cls[CLS_J]) begin
                    pc_d   = pc_q + 8'd1 + imm_q;
                    retire = 1'b1;
                end else if (cls[CLS_ADD]) begin
                    state_d = ST_WB;
                end else begin
                    state_d = ST_MEM;
                end
            end
            ST_MEM: begin
                if (cls[CLS_LW]) begin
                    state_d = ST_WB;
                end else begin
                    pc_d   = pc_q + 8'd1;
                    retire = 1'b1;
                end
            end
            ST_WB: begin
                pc_d   = pc_q + 8'd1;
                retire = 1'b1;
            end
            ST_HALT:   state_d = ST_HALT;
            default:   state_d = ST_IDLE;
        endcase
        // Running off the program (including a wrapped jump target) parks in HALT.
        if (retire) begin
            cnt_d   = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
            state_d = ({1'b0, pc_d} >= PROG_LIM) ? ST_HALT : ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            pc_q     <= '0;
            ir_q     <= '0;
            opcode_q <= '0;
            rs_q     <= '0;
            rt_q     <= '0;
            rd_q     <= '0;
            imm_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            opcode_q <= opcode_d;
            rs_q     <= rs_d;
            rt_q     <= rt_d;
            rd_q     <= rd_d;
            imm_q    <= imm_d;
            cnt_q    <= cnt_d;
        end
    end

    assign mem_op      = cls[CLS_LW] | cls[CLS_SW];
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign opcode      = opcode_q;
    assign rs_sel      = rs_q;
    assign rt_sel      = rt_q;
    assign rd_sel      = rd_q;
    assign imm         = imm_q;
    assign instr_count = cnt_q;
    assign busy        = (state_q != ST_IDLE) && (state_q != ST_HALT);
    assign halted      = (state_q == ST_HALT);
    assign reg_we      = (state_q == ST_WB);
    assign mem_to_reg  = (state_q == ST_WB) && cls[CLS_LW];
    assign mem_re      = (state_q == ST_MEM) && cls[CLS_LW];
    assign mem_we      = (state_q == ST_MEM) && cls[CLS_SW];
    assign alu_src     = mem_op &&
                         ((state_q == ST_EXEC) || (state_q == ST_MEM) || (state_q == ST_WB));

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: one task per scenario, inline checks,
// outputs sampled on the falling edge.
module tb_instr_sequencer;

    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             run = 1'b0;
`ifdef STEP_EN
    logic             step = 1'b0;
`endif
    logic [7:0]       imem_addr;
    logic [7:0]       imem_data = 8'h00;
    logic [7:0]       pc;
    logic [1:0]       opcode, rs_sel, rt_sel, rd_sel;
    logic [7:0]       imm;
    logic             alu_src, reg_we, mem_re, mem_we, mem_to_reg, busy, halted;
    logic [CNT_W-1:0] instr_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    instr_sequencer #(.PROG_LEN(8), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
`ifdef STEP_EN
        .step        (step),
`endif
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .pc          (pc),
        .opcode      (opcode),
        .rs_sel      (rs_sel),
        .rt_sel      (rt_sel),
        .rd_sel      (rd_sel),
        .imm         (imm),
        .alu_src     (alu_src),
        .reg_we      (reg_we),
        .mem_re      (mem_re),
        .mem_we      (mem_we),
        .mem_to_reg  (mem_to_reg),
        .busy        (busy),
        .halted      (halted),
        .instr_count (instr_count)
    );

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        run   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [59:0] all_out;
        reset = 1'b1;
        run   = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            all_out = {busy, halted, reg_we, mem_re, mem_we, mem_to_reg, alu_src,
                       pc, imem_addr, opcode, rs_sel, rt_sel, rd_sel, imm, instr_count,
                       5'b0};
            checks++;
            if (all_out !== 60'h0) begin
                failures++;
                $display("FAIL reset_idle cycle=%0d got=%h exp=0", c, all_out);
            end
        end
    endtask

    task automatic test_add();
        imem_data = 8'h1B;
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            checks++;
            if (reg_we !== (c == 4)) begin
                failures++;
                $display("FAIL add_reg_we cycle=%0d got=%b exp=%b", c, reg_we, (c == 4));
            end
            checks++;
            if (busy !== (c <= 4)) begin
                failures++;
                $display("FAIL add_busy cycle=%0d got=%b exp=%b", c, busy, (c <= 4));
            end
            if (c == 4) begin
                checks++;
                if (rd_sel !== 2'd3 || mem_to_reg !== 1'b0 || alu_src !== 1'b0) begin
                    failures++;
                    $display("FAIL add_wb_fields rd=%0d m2r=%b alu_src=%b exp rd=3 m2r=0 alu_src=0",
                             rd_sel, mem_to_reg, alu_src);
                end
            end
            @(negedge clk);
        end
        checks++;
        if (pc !== 8'd1 || imem_addr !== 8'd1 || instr_count !== 16'd1) begin
            failures++;
            $display("FAIL add_retire pc=%h addr=%h cnt=%0d exp pc=01 addr=01 cnt=1",
                     pc, imem_addr, instr_count);
        end
    endtask

    task automatic test_lw();
        imem_data = 8'h59;
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            checks++;
            if ({mem_re, reg_we, mem_to_reg, alu_src} !==
                {(c == 4), (c == 5), (c == 5), (c >= 3)}) begin
                failures++;
                $display("FAIL lw_strobes cycle=%0d got re/we/m2r/src=%b%b%b%b exp=%b%b%b%b",
                         c, mem_re, reg_we, mem_to_reg, alu_src,
                         (c == 4), (c == 5), (c == 5), (c >= 3));
            end
            if (c == 3) begin
                checks++;
                if (imm !== 8'h01 || opcode !== 2'b01 || rs_sel !== 2'd1 || rt_sel !== 2'd2) begin
                    failures++;
                    $display("FAIL lw_fields imm=%h op=%b rs=%0d rt=%0d exp imm=01 op=01 rs=1 rt=2",
                             imm, opcode, rs_sel, rt_sel);
                end
            end
            @(negedge clk);
        end
        checks++;
        if (pc !== 8'd2 || instr_count !== 16'd2) begin
            failures++;
            $display("FAIL lw_retire pc=%h cnt=%0d exp pc=02 cnt=2", pc, instr_count);
        end
    endtask

    task automatic test_sw();
        imem_data = 8'h86;
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            checks++;
            if ({mem_we, reg_we, mem_re, alu_src} !==
                {(c == 4), 1'b0, 1'b0, (c == 3 || c == 4)}) begin
                failures++;
                $display("FAIL sw_strobes cycle=%0d got we/rwe/re/src=%b%b%b%b exp=%b00%b",
                         c, mem_we, reg_we, mem_re, alu_src, (c == 4), (c == 3 || c == 4));
            end
            if (c == 3) begin
                checks++;
                if (imm !== 8'hFE || rs_sel !== 2'd0 || rt_sel !== 2'd1) begin
                    failures++;
                    $display("FAIL sw_fields imm=%h rs=%0d rt=%0d exp imm=fe rs=0 rt=1",
                             imm, rs_sel, rt_sel);
                end
            end
            @(negedge clk);
        end
        checks++;
        if (pc !== 8'd3 || instr_count !== 16'd3 || busy !== 1'b0) begin
            failures++;
            $display("FAIL sw_retire pc=%h cnt=%0d busy=%b exp pc=03 cnt=3 busy=0",
                     pc, instr_count, busy);
        end
    endtask

    task automatic test_jump();
        imem_data = 8'hFE;
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            checks++;
            if ({reg_we, mem_re, mem_we, mem_to_reg, alu_src} !== 5'b0 || busy !== 1'b1) begin
                failures++;
                $display("FAIL jump_strobes cycle=%0d got=%b%b%b%b%b busy=%b exp=00000 busy=1",
                         c, reg_we, mem_re, mem_we, mem_to_reg, alu_src, busy);
            end
            @(negedge clk);
        end
        checks++;
        if (pc !== 8'd2 || instr_count !== 16'd4 || halted !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL jump_retire pc=%h cnt=%0d halted=%b busy=%b exp pc=02 cnt=4 halted=0 busy=0",
                     pc, instr_count, halted, busy);
        end
    endtask

    task automatic test_jump_halt();
        do_reset();
        imem_data = 8'hFE;
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (halted !== 1'b1 || pc !== 8'hFF || busy !== 1'b0 || instr_count !== 16'd1) begin
            failures++;
            $display("FAIL jump_halt halted=%b pc=%h busy=%b cnt=%0d exp halted=1 pc=ff busy=0 cnt=1",
                     halted, pc, busy, instr_count);
        end
        run = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (halted !== 1'b1 || busy !== 1'b0 || pc !== 8'hFF) begin
                failures++;
                $display("FAIL halt_hold cycle=%0d halted=%b busy=%b pc=%h exp halted=1 busy=0 pc=ff",
                         c, halted, busy, pc);
            end
        end
        run = 1'b0;
        do_reset();
        @(negedge clk);
        checks++;
        if (halted !== 1'b0 || pc !== 8'h00) begin
            failures++;
            $display("FAIL halt_cleared halted=%b pc=%h exp halted=0 pc=00", halted, pc);
        end
    endtask

    task automatic test_reset_mid();
        logic [59:0] all_out;
        do_reset();
        imem_data = 8'h86;
        run = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (mem_we !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_mem got mem_we=%b exp=1", mem_we);
        end
        reset = 1'b1;
        run   = 1'b0;
        @(negedge clk);
        all_out = {busy, halted, reg_we, mem_re, mem_we, mem_to_reg, alu_src,
                   pc, imem_addr, opcode, rs_sel, rt_sel, rd_sel, imm, instr_count, 5'b0};
        checks++;
        if (all_out !== 60'h0) begin
            failures++;
            $display("FAIL rst_mid_outputs got=%h exp=0", all_out);
        end
        reset = 1'b0;
    endtask

    task automatic test_back_to_back();
        do_reset();
        imem_data = 8'h1B;
        run = 1'b1;
        @(negedge clk);
        for (int c = 1; c <= 10; c++) begin
            checks++;
            if (busy !== !(c == 5 || c == 10)) begin
                failures++;
                $display("FAIL b2b_busy cycle=%0d got=%b exp=%b", c, busy, !(c == 5 || c == 10));
            end
            if (c == 10) begin
                run = 1'b0;
                checks++;
                if (pc !== 8'd2 || instr_count !== 16'd2) begin
                    failures++;
                    $display("FAIL b2b_count pc=%h cnt=%0d exp pc=02 cnt=2", pc, instr_count);
                end
            end
            @(negedge clk);
        end
    endtask

`ifdef STEP_EN
    task automatic test_step();
        do_reset();
        imem_data = 8'h1B;
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            checks++;
            if (busy !== (c <= 4)) begin
                failures++;
                $display("FAIL step_busy cycle=%0d got=%b exp=%b", c, busy, (c <= 4));
            end
            @(negedge clk);
        end
        checks++;
        if (pc !== 8'd1 || instr_count !== 16'd1) begin
            failures++;
            $display("FAIL step_count pc=%h cnt=%0d exp pc=01 cnt=1", pc, instr_count);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_add();
        test_lw();
        test_sw();
        test_jump();
        test_jump_halt();
        test_reset_mid();
        test_back_to_back();
`ifdef STEP_EN
        test_step();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Multi-cycle fetch/decode/execute controller for the 8-bit CPU. It owns the program counter, drives the instruction memory read address, and latches the returned byte into an instruction register. It decodes the 2-bit opcode and emits one-cycle-accurate strobes to the register file, ALU and data memory. It sits between the combinational instruction memory and the datapath, and is the only block that advances the PC.

## Interface
- PROG_LEN, 8, number of valid program words; a PC at or above this value halts the machine
- CNT_W, 16, width of the retired-instruction counter
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- run  in  1  level; while high, the sequencer starts a new instruction from IDLE
- step  in  1  one-cycle pulse; starts exactly one instruction from IDLE (present only with STEP_EN)
- imem_addr  out  8  instruction memory read address; always equals pc
- imem_data  in  8  instruction byte, combinational from imem_addr
- pc  out  8  current program counter
- opcode  out  2  IR[7:6]
- rs_sel  out  2  IR[5:4]
- rt_sel  out  2  IR[3:2]
- rd_sel  out  2  IR[1:0]
- imm  out  8  sign-extended IR[1:0] for lw/sw; sign-extended IR[5:0] for jump
- alu_src  out  1  ALU B operand selects imm
- reg_we  out  1  register file write strobe
- mem_re / mem_we  out  1 each  data memory read / write strobes
- mem_to_reg  out  1  write-back source is data memory
- busy  out  1  high in any state except IDLE and HALT
- halted  out  1  high in HALT
- instr_count  out  CNT_W  instructions retired since reset

## Operation
- ISA: op 00 = add (rd = rs + rt); 01 = lw (rt = M[rs + imm]); 10 = sw (M[rs + imm] = rt); 11 = jump (pc = pc + 1 + sext(IR[5:0])).
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
- IDLE -> FETCH when run=1 or step=1. In FETCH, IR <= imem_data. FETCH -> DECODE.
- DECODE registers the field and imm outputs, which are held until the next FETCH. DECODE -> EXEC.
- EXEC:
  - add -> WB
  - lw and sw -> MEM
  - jump: pc <= target; instruction retires; -> IDLE
- MEM:
  - lw: mem_re=1; -> WB
  - sw: mem_we=1; pc <= pc+1; instruction retires; -> IDLE
- WB: reg_we=1; mem_to_reg=1 for lw only; pc <= pc+1; instruction retires; -> IDLE.
- Retiring an instruction increments instr_count, which saturates at all-ones.
- On the IDLE entry after retirement, if the new pc >= PROG_LEN, go to HALT instead of IDLE. This also applies when a jump target is at or above PROG_LEN.
- HALT is left only by reset.
- pc arithmetic is mod 256. A jump target below 0 wraps, e.g. 0xFF, which is >= PROG_LEN and therefore halts.
- A jump to self (IR=0xFF, offset -1) is legal and loops forever.
- run falling mid-instruction: the current instruction completes and the sequencer stops in IDLE.
- run and step both high: treated as run.

## Timing
- Reset values: pc=0, imem_addr=0, IR=0, all field outputs and imm 0, every strobe 0, busy=0, halted=0, instr_count=0, state IDLE.
- Reset asserted mid-instruction overrides all state on that edge; no strobe is emitted in the following cycle.
- Latency from the IDLE exit edge to retirement, inclusive of the FETCH cycle:
  - add: 4 cycles
  - lw: 5 cycles
  - sw: 4 cycles
  - jump: 3 cycles
- Strobes are registered-state decodes, high for exactly one cycle each.
- alu_src is high during EXEC, MEM and WB for lw/sw only.
- Back-to-back operation: with run held high, FETCH of the next instruction immediately follows one IDLE cycle.

## Configuration
- STEP_EN defined: the step port exists, and a one-cycle pulse in IDLE executes one instruction. A pulse arriving while busy is ignored.
- STEP_EN undefined: no step port; only run starts instructions.

## Structure
- cpu_pkg holds:
  - opcode localparams OP_ADD, OP_LW, OP_SW, OP_J
  - state encoding localparams
  - instruction field bit positions
- One sub-module: instr_decoder, purely combinational. It maps IR to fields, imm and an instruction-class one-hot. The FSM in instr_sequencer combines the class with the current state to produce strobes.

## Test plan
- Reset with run=0: all outputs are 0 and the state stays IDLE for 10 cycles; imem_addr=0.
- imem_data=0x1B (add r1,r2,r3), run pulse:
  - FETCH through WB takes 4 cycles
  - reg_we is high only in cycle 4, with rd_sel=3
  - pc becomes 1 and instr_count becomes 1
- imem_data=0x59 (lw r2 <- [r1 + 1]):
  - alu_src is high from EXEC onward, and imm=0x01
  - mem_re is high in cycle 4; reg_we and mem_to_reg are high in cycle 5
  - pc increments
- imem_data=0x86 (sw, rs=0, rt=1, imm=-2):
  - imm=0xFE
  - mem_we is high one cycle in MEM; reg_we is never high
- pc=3, imem_data=0xFE (jump, offset -2): after 3 cycles pc=2 with no strobes. Repeat from pc=0 with the same instruction: target 0xFF causes HALT, halted=1, and halted is held until reset.
- With run=1, reset asserted during the MEM cycle of an sw: mem_we stays 0 in the next cycle and all outputs return to reset values. With STEP_EN, one step pulse executes exactly one add, then the sequencer remains in IDLE.
